// File: rtl/serpent_xts_encrypt_sector.sv
// XTS-mode sector encryptor sequencing an external Serpent block core.
// Encrypts the sector tweak once, then runs P^T -> core -> ^T for each block while stepping T by alpha.
module serpent_xts_encrypt_sector #(
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
    input  logic [127:0]     i_sector,
    input  logic [CNT_W-1:0] i_num_blocks,
    input  logic [127:0]     i_data,
    input  logic             i_data_valid,
    output logic             o_data_ready,
    output logic [127:0]     o_data,
    output logic             o_data_valid,
    input  logic             i_data_ready,
    output logic             o_cipher_start,
    output logic             o_cipher_key_sel,
    output logic [127:0]     o_cipher_data,
    input  logic [127:0]     i_cipher_data,
    input  logic             i_cipher_valid,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [2:0] {IDLE, TWEAK, LOAD, CIPHER, OUT} state_t;

    state_t             state_q, state_d;
    logic [127:0]       tweak_q;
    logic [CNT_W-1:0]   cnt_q;

    // Multiply by the primitive element in GF(2^128), reduction polynomial x^128+x^7+x^2+x+1.
    function automatic logic [127:0] mul_alpha(input logic [127:0] t);
        return {t[126:0], 1'b0} ^ (t[127] ? 128'h87 : 128'h0);
    endfunction

    assign o_data_ready = (state_q == LOAD);
    assign o_busy       = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start && i_num_blocks != '0) state_d = TWEAK;
            TWEAK:   if (i_cipher_valid) state_d = LOAD;
            LOAD:    if (i_data_valid) state_d = CIPHER;
            CIPHER:  if (i_cipher_valid) state_d = OUT;
            OUT:     if (i_data_ready) state_d = (cnt_q == CNT_W'(1)) ? IDLE : LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tweak_q          <= '0;
            cnt_q            <= '0;
            o_data           <= '0;
            o_data_valid     <= 1'b0;
            o_cipher_start   <= 1'b0;
            o_cipher_key_sel <= 1'b0;
            o_cipher_data    <= '0;
            o_done           <= 1'b0;
        end else begin
            o_cipher_start <= 1'b0;
            o_done         <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        if (i_num_blocks != '0) begin
                            cnt_q            <= i_num_blocks;
                            o_cipher_data    <= i_sector;
                            o_cipher_key_sel <= 1'b1;
                            o_cipher_start   <= 1'b1;
                        end else begin
                            o_done <= 1'b1;
                        end
                    end
                end
                TWEAK: begin
                    if (i_cipher_valid) tweak_q <= i_cipher_data;
                end
                LOAD: begin
                    if (i_data_valid) begin
                        o_cipher_data    <= i_data ^ tweak_q;
                        o_cipher_key_sel <= 1'b0;
                        o_cipher_start   <= 1'b1;
                    end
                end
                CIPHER: begin
                    if (i_cipher_valid) begin
                        o_data       <= i_cipher_data ^ tweak_q;
                        o_data_valid <= 1'b1;
                    end
                end
                OUT: begin
                    // Output is held until downstream takes it; only then advance the tweak.
                    if (i_data_ready) begin
                        o_data_valid <= 1'b0;
                        tweak_q      <= mul_alpha(tweak_q);
                        cnt_q        <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) o_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serpent_xts_encrypt_sector.sv
// Directed vector bench for serpent_xts_encrypt_sector with a rotate-left-8, 4-cycle-latency core stand-in.
module tb_serpent_xts_encrypt_sector;

    logic         i_clk = 1'b0;
    logic         i_rstn;
    logic         i_start;
    logic [127:0] i_sector;
    logic [5:0]   i_num_blocks;
    logic [127:0] i_data;
    logic         i_data_valid;
    logic         o_data_ready;
    logic [127:0] o_data;
    logic         o_data_valid;
    logic         i_data_ready;
    logic         o_cipher_start;
    logic         o_cipher_key_sel;
    logic [127:0] o_cipher_data;
    logic [127:0] i_cipher_data;
    logic         i_cipher_valid;
    logic         o_busy;
    logic         o_done;

    serpent_xts_encrypt_sector #(.CNT_W(6)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_sector(i_sector),
        .i_num_blocks(i_num_blocks), .i_data(i_data), .i_data_valid(i_data_valid),
        .o_data_ready(o_data_ready), .o_data(o_data), .o_data_valid(o_data_valid),
        .i_data_ready(i_data_ready), .o_cipher_start(o_cipher_start),
        .o_cipher_key_sel(o_cipher_key_sel), .o_cipher_data(o_cipher_data),
        .i_cipher_data(i_cipher_data), .i_cipher_valid(i_cipher_valid),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string              name;
        logic [127:0]       sector;
        int                 n;
        logic [2:0][127:0]  p;
        logic [2:0][127:0]  exp;
    } vec_t;

    vec_t             vecs[5];
    logic [128:0]     req_q[$];
    int               done_cnt = 0;
    int               n_cmp = 0;
    int               n_err = 0;

    function automatic logic [127:0] rotl8(input logic [127:0] x);
        return {x[119:0], x[127:120]};
    endfunction

    // Core stand-in: latch request, answer rotl8(data) four clocks after the start edge.
    initial begin
        logic [127:0] d;
        i_cipher_valid = 1'b0;
        i_cipher_data  = '0;
        forever begin
            @(negedge i_clk);
            if (o_cipher_start) begin
                req_q.push_back({o_cipher_key_sel, o_cipher_data});
                d = rotl8(o_cipher_data);
                repeat (3) @(posedge i_clk);
                #1 i_cipher_valid = 1'b1;
                i_cipher_data = d;
                @(posedge i_clk);
                #1 i_cipher_valid = 1'b0;
                i_cipher_data = '0;
            end
        end
    end

    always @(negedge i_clk) if (o_done) done_cnt++;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic start_sector(input logic [127:0] sector, input int n);
        @(negedge i_clk);
        i_start = 1'b1;
        i_sector = sector;
        i_num_blocks = 6'(n);
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic send_block(input string nm, input logic [127:0] p);
        int k = 0;
        i_data = p;
        i_data_valid = 1'b1;
        while (!o_data_ready && k < 100) begin
            @(negedge i_clk);
            k++;
        end
        chk({nm, "_ready"}, 128'(o_data_ready), 128'(1));
        @(posedge i_clk);
        #1 i_data_valid = 1'b0;
    endtask

    task automatic get_block(input string nm, input logic [127:0] exp, input int hold);
        int k = 0;
        int bad = 0;
        int rq;
        while (!o_data_valid && k < 100) begin
            @(negedge i_clk);
            k++;
        end
        chk({nm, "_valid"}, 128'(o_data_valid), 128'(1));
        chk({nm, "_data"}, o_data, exp);
        if (hold > 0) begin
            rq = req_q.size();
            i_start = 1'b1;
            i_num_blocks = 6'd5;
            for (int h = 0; h < hold; h++) begin
                @(negedge i_clk);
                if (o_data !== exp || o_data_valid !== 1'b1) bad++;
            end
            i_start = 1'b0;
            chk({nm, "_hold_stable"}, 128'(bad), 128'(0));
            chk({nm, "_hold_no_req"}, 128'(req_q.size()), 128'(rq));
        end
        i_data_ready = 1'b1;
        @(posedge i_clk);
        #1 i_data_ready = 1'b0;
    endtask

    task automatic run_sector(input vec_t v, input int hold);
        int base = req_q.size();
        int dbase = done_cnt;
        start_sector(v.sector, v.n);
        chk({v.name, "_busy"}, 128'(o_busy), 128'(1));
        for (int b = 0; b < v.n; b++) begin
            send_block(v.name, v.p[b]);
            get_block(v.name, v.exp[b], (b == 0) ? hold : 0);
        end
        repeat (2) @(negedge i_clk);
        chk({v.name, "_done_cnt"}, 128'(done_cnt - dbase), 128'(1));
        chk({v.name, "_req_cnt"}, 128'(req_q.size() - base), 128'(v.n + 1));
        chk({v.name, "_idle"}, 128'(o_busy), 128'(0));
        if (req_q.size() > base)
            chk({v.name, "_tweak_req"}, 128'(req_q[base]), {1'b0, 1'b1, v.sector} >> 0);
    endtask

    initial begin
        int base;
        int dbase;
        vecs[0] = '{"zero_sector", 128'h0, 1, '{default: '0}, '{default: '0}};
        vecs[1] = '{"two_blocks", 128'h1, 2, '{128'h0, 128'h0, 128'h0},
                    '{128'h0, 128'h20200, 128'h10100}};
        vecs[2] = '{"tweak_wrap", 128'h1 << 119, 2, '{128'h0, 128'h0, 128'h0},
                    '{128'h0, 128'h8787, {1'b1, 119'h0, 8'h80}}};
        vecs[3] = '{"nonzero_pt", 128'h1, 1, '{128'h0, 128'h0, 128'h55},
                    '{128'h0, 128'h0, 128'h15400}};
        vecs[4] = '{"three_blocks", 128'h2, 3, '{128'h3, 128'h2, 128'h1},
                    '{128'h80b00, 128'h40600, 128'h20300}};

        i_rstn = 1'b0;
        i_start = 1'b0;
        i_sector = '0;
        i_num_blocks = '0;
        i_data = '0;
        i_data_valid = 1'b0;
        i_data_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("reset_outputs",
            {o_data ^ o_cipher_data, 122'h0, o_data_valid, o_data_ready, o_cipher_start,
             o_cipher_key_sel, o_busy, o_done} >> 0, 128'h0);
        chk("reset_data", o_data | o_cipher_data, 128'h0);
        i_rstn = 1'b1;

        for (int i = 0; i < 5; i++) run_sector(vecs[i], 0);

        // Backpressure in OUT, with a start request that must be ignored.
        run_sector(vecs[1], 10);

        // Zero-length sector.
        base = req_q.size();
        dbase = done_cnt;
        @(negedge i_clk);
        i_start = 1'b1;
        i_sector = 128'h1234;
        i_num_blocks = 6'd0;
        @(negedge i_clk);
        i_start = 1'b0;
        chk("zero_len_done", 128'(o_done), 128'(1));
        chk("zero_len_busy", 128'(o_busy), 128'(0));
        @(negedge i_clk);
        chk("zero_len_done_pulse", 128'(o_done), 128'(0));
        chk("zero_len_busy2", 128'(o_busy), 128'(0));
        repeat (6) @(negedge i_clk);
        chk("zero_len_no_req", 128'(req_q.size()), 128'(base));
        chk("zero_len_done_cnt", 128'(done_cnt - dbase), 128'(1));

        // Reset while block 2 of 3 is in the core; the late core answer must be ignored.
        base = req_q.size();
        dbase = done_cnt;
        start_sector(128'h1, 3);
        send_block("rst_seq", 128'h0);
        get_block("rst_seq_b0", 128'h10100, 0);
        send_block("rst_seq", 128'h0);
        @(posedge i_clk);
        #1 i_rstn = 1'b0;
        #1;
        chk("rst_mid_ctrl",
            128'({o_data_valid, o_data_ready, o_cipher_start, o_cipher_key_sel, o_busy, o_done}),
            128'h0);
        chk("rst_mid_data", o_data | o_cipher_data, 128'h0);
        @(posedge i_clk);
        #1 i_rstn = 1'b1;
        repeat (8) @(negedge i_clk);
        chk("rst_stray_busy", 128'(o_busy), 128'(0));
        chk("rst_stray_valid", 128'(o_data_valid), 128'(0));
        chk("rst_no_done", 128'(done_cnt - dbase), 128'(0));
        chk("rst_req_cnt", 128'(req_q.size() - base), 128'(3));
        chk("rst_stray_data", o_data, 128'h0);

        // Clean operation after the abandoned sector.
        run_sector(vecs[4], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
